// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constant helpers for the UART receive path
// and the transmitter that reuses uart_baud_tick.
//   parity_e    - parity mode encoding (none / odd / even)
//   rx_state_e  - receiver FSM states
//   calc_div        - clock cycles per oversample tick
//   calc_char_bits  - line bits per character (start + data + parity + stop)
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_ODD  = 2'd1,
    PAR_EVEN = 2'd2
  } parity_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  function automatic int calc_div(input int clk, input int baud, input int os);
    return clk / (baud * os);
  endfunction

  function automatic int calc_char_bits(input int d, input int p, input int s);
    return 1 + d + ((p != 0) ? 1 : 0) + s;
  endfunction

endpackage

// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: receiver result bundle.
//   rx_data    - last received word
//   rx_valid   - one-cycle frame-complete pulse
//   rx_busy    - frame in progress
//   parity_err / frame_err / break_det - per-frame status, valid with rx_data
//   rx_t35     - inter-frame silence pulse (only when RX_T35_EN is defined)
// master: receiver side (drives everything); slave: consumer side.
interface uart_rx_frame_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
`ifdef RX_T35_EN
  logic                 rx_t35;

  modport master (output rx_data, rx_valid, rx_busy, parity_err, frame_err, break_det, rx_t35);
  modport slave  (input  rx_data, rx_valid, rx_busy, parity_err, frame_err, break_det, rx_t35);
`else
  modport master (output rx_data, rx_valid, rx_busy, parity_err, frame_err, break_det);
  modport slave  (input  rx_data, rx_valid, rx_busy, parity_err, frame_err, break_det);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: divide-by-DIV tick generator.
//   clk_in, rst_in - clock, synchronous active-high reset
//   clr            - synchronous clear, holds the divider at 0
//   en             - count enable
//   tick           - one-cycle pulse on each wrap of the 0..DIV-1 counter
// With the divider cleared on the cycle before counting starts, the first
// tick appears DIV cycles later.
module uart_baud_tick #(
  parameter int DIV = 10
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in || clr)  cnt <= '0;
    else if (en)        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = en && !clr && (cnt == LAST);
endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: parametrised UART receiver (data width, parity, stop bits)
// with start-bit glitch rejection and parity / framing / break reporting.
//   clk_in   - system clock
//   rst_in   - synchronous active-high reset
//   rs232_rx - asynchronous serial line, idles high
//   rx_if    - result bundle (uart_rx_frame_if.master)
// Optional: define RX_T35_EN to add the rx_t35 inter-frame silence pulse;
// ticks then run free in IDLE so silence can be measured.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic            rs232_rx,
  uart_rx_frame_if.master rx_if
);
  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int M   = OVERSAMPLE / 2;
  localparam int SW  = $clog2(OVERSAMPLE);

  localparam logic [SW-1:0] S_VM1  = SW'(M - 1);
  localparam logic [SW-1:0] S_VM   = SW'(M);
  localparam logic [SW-1:0] S_VP1  = SW'(M + 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BC_DLAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    BC_SLAST = 4'(STOP_BITS - 1);

  localparam bit HAS_PAR = (PARITY != 0);
  localparam bit ODD_PAR = (PARITY == int'(PAR_ODD));

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_START = ST_START;
  localparam logic [2:0] S_DATA  = ST_DATA;
  localparam logic [2:0] S_PAR   = ST_PARITY;
  localparam logic [2:0] S_STOP  = ST_STOP;

  logic                 rx_m, rxs;
  logic [2:0]           state;
  logic                 armed;
  logic [SW-1:0]        s;
  logic [3:0]           bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 v0, v1, par_bit, ferr_acc;
  logic                 tick, tick_clr, tick_en;
  logic                 accept, samp, bit_end, vote;
  logic                 fe_now, pe_now, brk_now;

  // Frame results are staged on the last-stop vote and published together
  // with rx_valid one cycle later, so data and flags always change at once.
  logic                 pend;
  logic [DATA_BITS-1:0] stg_data, data_q;
  logic                 stg_pe, stg_fe, stg_brk;
  logic                 pe_q, fe_q, brk_q, valid_q;

  assign accept  = (state == S_IDLE) && armed && !rxs;
  assign samp    = tick && (s == S_VP1);
  assign bit_end = tick && (s == S_LAST);
  // third sample is the live synchronised line at s = M+1
  assign vote    = (v0 & v1) | (v0 & rxs) | (v1 & rxs);

  assign fe_now  = ferr_acc | ~vote;
  assign pe_now  = HAS_PAR && (par_bit != ((^shreg) ^ ODD_PAR));
  assign brk_now = fe_now && (shreg == '0) && (!HAS_PAR || !par_bit);

`ifdef RX_T35_EN
  assign tick_clr = accept;
  assign tick_en  = 1'b1;
`else
  assign tick_clr = (state == S_IDLE);
  assign tick_en  = (state != S_IDLE);
`endif

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .clr    (tick_clr),
    .en     (tick_en),
    .tick   (tick)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rx_m     <= 1'b0;
      rxs      <= 1'b0;
      state    <= S_IDLE;
      armed    <= 1'b0;
      s        <= '0;
      bitcnt   <= '0;
      shreg    <= '0;
      v0       <= 1'b0;
      v1       <= 1'b0;
      par_bit  <= 1'b0;
      ferr_acc <= 1'b0;
      pend     <= 1'b0;
      stg_data <= '0;
      stg_pe   <= 1'b0;
      stg_fe   <= 1'b0;
      stg_brk  <= 1'b0;
      data_q   <= '0;
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      brk_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      rx_m    <= rs232_rx;
      rxs     <= rx_m;
      pend    <= 1'b0;
      valid_q <= pend;
      if (pend) begin
        data_q <= stg_data;
        pe_q   <= stg_pe;
        fe_q   <= stg_fe;
        brk_q  <= stg_brk;
      end

      if (state != S_IDLE && tick) begin
        s <= (s == S_LAST) ? '0 : s + 1'b1;
        if (s == S_VM1) v0 <= rxs;
        if (s == S_VM)  v1 <= rxs;
      end

      case (state)
        S_IDLE: begin
          if (rxs) armed <= 1'b1;
          if (accept) begin
            state    <= S_START;
            s        <= '0;
            bitcnt   <= '0;
            ferr_acc <= 1'b0;
          end
        end
        S_START: begin
          if (samp && vote) state <= S_IDLE;   // glitch, not a start bit
          else if (bit_end) state <= S_DATA;
        end
        S_DATA: begin
          if (samp) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (bit_end) begin
            if (bitcnt == BC_DLAST) begin
              bitcnt <= '0;
              state  <= HAS_PAR ? S_PAR : S_STOP;
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        S_PAR: begin
          if (samp)    par_bit <= vote;
          if (bit_end) state   <= S_STOP;
        end
        S_STOP: begin
          if (samp) begin
            if (bitcnt == BC_SLAST) begin
              // leave mid-bit so the next start edge is not missed
              state    <= S_IDLE;
              pend     <= 1'b1;
              stg_data <= shreg;
              stg_pe   <= pe_now;
              stg_fe   <= fe_now;
              stg_brk  <= brk_now;
              if (brk_now) armed <= 1'b0;   // wait for line high before next start
            end else begin
              ferr_acc <= fe_now;
            end
          end
          if (bit_end) bitcnt <= bitcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign rx_if.rx_data    = data_q;
  assign rx_if.rx_valid   = valid_q;
  assign rx_if.rx_busy    = (state != S_IDLE);
  assign rx_if.parity_err = pe_q;
  assign rx_if.frame_err  = fe_q;
  assign rx_if.break_det  = brk_q;

`ifdef RX_T35_EN
  localparam int T35 = 7 * calc_char_bits(DATA_BITS, PARITY, STOP_BITS) * OVERSAMPLE / 2;

  logic [23:0] sil_cnt;
  logic        t35_arm, t35_q;

  // Silence is measured in ticks of idle-high line after a completed frame;
  // one pulse per gap, re-armed by the next frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sil_cnt <= '0;
      t35_arm <= 1'b0;
      t35_q   <= 1'b0;
    end else begin
      t35_q <= 1'b0;
      if (accept) begin
        sil_cnt <= '0;
      end else if (pend) begin
        sil_cnt <= '0;
        t35_arm <= 1'b1;
      end else if (t35_arm && tick && state == S_IDLE && rxs) begin
        sil_cnt <= sil_cnt + 1'b1;
        if (sil_cnt == 24'(T35 - 1)) begin
          t35_q   <= 1'b1;
          t35_arm <= 1'b0;
        end
      end
    end
  end

  assign rx_if.rx_t35 = t35_q;
`endif
endmodule
